mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 13 +
 rtl/mem_arbiter_rr_pick2.sv | 20 ++
 rtl/mem_arbiter.sv | 106 ++++++++++
 tb/tb_mem_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared widths and controller state encoding for the two-port memory arbiter.
package mem_arbiter_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 12;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin pick: on a tie the port not granted last wins; purely combinational.
// Zero latency; no backpressure of its own, the caller decides when a pick is consumed.
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic grant_vld,
  output logic grant_id
);

  always_comb begin
    grant_vld = req0 | req1;
    if (req0 && req1) begin
      grant_id = ~last;
    end else begin
      grant_id = req1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port round-robin memory arbiter: one access per 3 cycles, ack two cycles after the winning req.
// Losing or late requesters are back-pressured by simply holding req until their ack arrives.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef struct packed {
    logic              id;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } lat_t;

  state_t state_q;
  state_t state_d;
  lat_t   lat_q;
  logic   last_q;
  logic   grant_vld;
  logic   grant_id;

  rr_pick2 u_pick (
    .req0      (req0),
    .req1      (req1),
    .last      (last_q),
    .grant_vld (grant_vld),
    .grant_id  (grant_id)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_vld) state_d = ACCESS;
      ACCESS:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Requests are latched only in IDLE, so later input changes cannot disturb an access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_q  <= '0;
      last_q <= 1'b1;
      rdata0 <= '0;
      rdata1 <= '0;
    end else begin
      if (state_q == IDLE && grant_vld) begin
        lat_q.id    <= grant_id;
        lat_q.we    <= grant_id ? we1 : we0;
        lat_q.addr  <= grant_id ? addr1 : addr0;
        lat_q.wdata <= grant_id ? wdata1 : wdata0;
        last_q      <= grant_id;
      end
      if (state_q == ACCESS && !lat_q.we) begin
        if (lat_q.id) begin
          rdata1 <= mem_rdata;
        end else begin
          rdata0 <= mem_rdata;
        end
      end
    end
  end

  // Write strobe is gated by rst directly so a reset landing mid-access never commits the write.
  always_comb begin
    busy   = (state_q != IDLE);
    mem_we = (state_q == ACCESS) && lat_q.we && !rst;
    ack0   = (state_q == DONE) && !lat_q.id;
    ack1   = (state_q == DONE) && lat_q.id;
  end

  assign mem_addr  = lat_q.addr;
  assign mem_wdata = lat_q.wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by random traffic, checked against a transaction-level model.
module tb_mem_arbiter;

  localparam int DW = 16;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1, mem_we, busy;
  logic [DW-1:0] rdata0, rdata1, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  logic [DW-1:0] mem [0:4095];

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  mem_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .req1      (req1),
    .we0       (we0),
    .we1       (we1),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .ack0      (ack0),
    .ack1      (ack1),
    .rdata0    (rdata0),
    .rdata1    (rdata1),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Transaction-level model: at most one access in flight, granted when the arbiter is free.
  int            cyc      = 0;
  int            grant_at = -100;
  int            free_at  = 0;
  bit            t_port   = 1'b0;
  bit            t_we     = 1'b0;
  logic [AW-1:0] t_addr   = '0;
  logic [DW-1:0] t_wd     = '0;
  bit            last_g   = 1'b1;
  logic [DW-1:0] ref_mem [0:4095];
  logic [DW-1:0] exp_rd  [2];
  bit   [1:0]    acked    = 2'b00;
  bit            chk_en   = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s (cycle %0d): observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic set_port(input int p, input logic r, input logic w,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (p == 0) begin
      req0 = r; we0 = w; addr0 = a; wdata0 = d;
    end else begin
      req1 = r; we1 = w; addr1 = a; wdata1 = d;
    end
  endtask

  // One clock cycle: check outputs mid-cycle, advance the model, then return just after the next edge.
  task automatic step();
    bit in_access, in_done;
    @(negedge clk);
    in_access = (cyc == grant_at + 1);
    in_done   = (cyc == grant_at + 2);
    if (chk_en) begin
      check("ack0",   {31'd0, ack0},   {31'd0, in_done && !t_port});
      check("ack1",   {31'd0, ack1},   {31'd0, in_done && t_port});
      check("busy",   {31'd0, busy},   {31'd0, in_access || in_done});
      check("mem_we", {31'd0, mem_we}, {31'd0, in_access && t_we && !rst});
      check("rdata0", {16'd0, rdata0}, {16'd0, exp_rd[0]});
      check("rdata1", {16'd0, rdata1}, {16'd0, exp_rd[1]});
      if (in_access) begin
        check("mem_addr",  {20'd0, mem_addr},  {20'd0, t_addr});
        check("mem_wdata", {16'd0, mem_wdata}, {16'd0, t_wd});
      end
    end
    if (mem_we) mem[mem_addr] = mem_wdata;
    acked = 2'b00;
    if (in_done) acked[t_port] = 1'b1;
    if (rst) begin
      grant_at  = -100;
      free_at   = cyc + 1;
      last_g    = 1'b1;
      exp_rd[0] = '0;
      exp_rd[1] = '0;
    end else begin
      if (in_access) begin
        if (t_we) ref_mem[t_addr] = t_wd;
        else      exp_rd[t_port]  = ref_mem[t_addr];
      end
      if (cyc >= free_at && (req0 || req1)) begin
        t_port   = (req0 && req1) ? !last_g : req1;
        last_g   = t_port;
        t_we     = t_port ? we1 : we0;
        t_addr   = t_port ? addr1 : addr0;
        t_wd     = t_port ? wdata1 : wdata0;
        grant_at = cyc;
        free_at  = cyc + 3;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 5) == 0) return 12'hFFF;
    return AW'($urandom_range(0, 15));
  endfunction

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem[i]     = '0;
      ref_mem[i] = '0;
    end
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    rst = 1'b1;
    set_port(0, 1'b0, 1'b0, '0, '0);
    set_port(1, 1'b0, 1'b0, '0, '0);
    @(posedge clk);
    #1;

    // Reset state
    step();
    chk_en = 1'b1;
    steps(2);
    rst = 1'b0;
    steps(2);

    // Simultaneous reads: port 0 first, port 1 three cycles later
    set_port(0, 1'b1, 1'b0, 12'h010, '0);
    set_port(1, 1'b1, 1'b0, 12'h020, '0);
    steps(3);
    set_port(0, 1'b0, 1'b0, '0, '0);
    steps(3);
    set_port(1, 1'b0, 1'b0, '0, '0);
    steps(2);

    // Port 0 write then read back
    set_port(0, 1'b1, 1'b1, 12'h123, 16'hBEEF);
    steps(3);
    set_port(0, 1'b1, 1'b0, 12'h123, '0);
    steps(3);
    set_port(0, 1'b0, 1'b0, '0, '0);
    check("rd_beef", {16'd0, rdata0}, 32'h0000_BEEF);
    check("rd1_hold", {16'd0, rdata1}, 32'h0);
    steps(1);

    // Reset during the ACCESS cycle of a write aborts it
    set_port(0, 1'b1, 1'b1, 12'hFFF, 16'h5555);
    step();
    rst = 1'b1;
    set_port(0, 1'b0, 1'b0, '0, '0);
    step();
    rst = 1'b0;
    steps(2);
    set_port(0, 1'b1, 1'b0, 12'hFFF, '0);
    steps(3);
    set_port(0, 1'b0, 1'b0, '0, '0);
    check("rd_fff", {16'd0, rdata0}, 32'h0);
    step();

    // Port 1 read of 0x000 with the address changed mid-access
    set_port(0, 1'b1, 1'b1, 12'h000, 16'hA5A5);
    steps(3);
    set_port(0, 1'b0, 1'b0, '0, '0);
    set_port(1, 1'b1, 1'b0, 12'h000, '0);
    step();
    addr1 = 12'h123;
    steps(2);
    set_port(1, 1'b0, 1'b0, '0, '0);
    check("rd_orig", {16'd0, rdata1}, 32'h0000_A5A5);
    step();

    // Both ports held high: alternating grants
    set_port(0, 1'b1, 1'b0, 12'h123, '0);
    set_port(1, 1'b1, 1'b1, 12'h007, 16'h1234);
    steps(12);
    set_port(0, 1'b0, 1'b0, '0, '0);
    set_port(1, 1'b0, 1'b0, '0, '0);
    steps(3);

    // Port 0 back-to-back alone
    set_port(0, 1'b1, 1'b0, 12'h007, '0);
    steps(9);
    set_port(0, 1'b0, 1'b0, '0, '0);
    check("rd_b2b", {16'd0, rdata0}, 32'h0000_1234);
    steps(3);

    // Random traffic
    for (int k = 0; k < 600; k++) begin
      rst = ($urandom_range(0, 59) == 0);
      for (int p = 0; p < 2; p++) begin
        logic rq;
        rq = (p == 0) ? req0 : req1;
        if (!rq || acked[p]) begin
          if ($urandom_range(0, 99) < 55)
            set_port(p, 1'b1, 1'($urandom_range(0, 1)), rand_addr(), DW'($urandom));
          else
            set_port(p, 1'b0, 1'b0, '0, '0);
        end else if (cyc == grant_at + 1 && int'(t_port) == p && $urandom_range(0, 2) == 0) begin
          if (p == 0) begin
            addr0 = rand_addr(); wdata0 = DW'($urandom);
          end else begin
            addr1 = rand_addr(); wdata1 = DW'($urandom);
          end
        end
      end
      step();
    end
    rst = 1'b0;
    set_port(0, 1'b0, 1'b0, '0, '0);
    set_port(1, 1'b0, 1'b0, '0, '0);
    steps(6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
